// File: rtl/data_memory_read_interface_pkg.sv
// Shared types and load_type bit positions for the load-side byte-lane logic.
package data_memory_read_interface_pkg;

    localparam int LT_BYTE     = 0;
    localparam int LT_HWORD    = 1;
    localparam int LT_UNSIGNED = 2;

    typedef logic [31:0] word_t;
    typedef logic [15:0] hword_t;
    typedef logic [7:0]  byte_t;
    typedef logic [2:0]  ltype_t;
    typedef logic [4:0]  reg_idx_t;

    typedef struct packed {
        logic     valid;
        logic [1:0] offset;
        ltype_t   ltype;
        reg_idx_t dest;
    } req_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t dest;
        word_t    value;
        logic     misaligned;
    } out_t;

    function automatic byte_t byte_lane(word_t w, logic [1:0] off);
        byte_t b;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    function automatic hword_t hword_lane(word_t w, logic hi);
        return hi ? w[31:16] : w[15:0];
    endfunction

endpackage

// File: rtl/data_memory_read_interface_if.sv
// Load request / RAM return / completed-load bundle.
interface data_memory_read_interface_if;
    import data_memory_read_interface_pkg::*;

    logic     req_valid;
    word_t    long_addr;
    ltype_t   load_type;
    reg_idx_t dest_reg;
    word_t    mem_read_data;
    logic     out_valid;
    reg_idx_t out_dest_reg;
    word_t    load_value;
    logic     misaligned;

    modport master (
        output req_valid, long_addr, load_type, dest_reg, mem_read_data,
        input  out_valid, out_dest_reg, load_value, misaligned
    );

    modport slave (
        input  req_valid, long_addr, load_type, dest_reg, mem_read_data,
        output out_valid, out_dest_reg, load_value, misaligned
    );

endinterface

// File: rtl/data_memory_read_interface_load_extract.sv
// Pure combinational lane select plus sign/zero extension of a returned word.
module data_memory_read_interface_load_extract
    import data_memory_read_interface_pkg::*;
(
    input  logic [1:0] i_offset,
    input  ltype_t     i_load_type,
    input  word_t      i_word,
    output word_t      o_value,
    output logic       o_misaligned
);

    byte_t  w_byte;
    hword_t w_hword;

    assign w_byte  = byte_lane(i_word, i_offset);
    assign w_hword = hword_lane(i_word, i_offset[1]);

    // BYTE is tested first so it wins when both width bits are set.
    always_comb begin
        o_value      = i_word;
        o_misaligned = 1'b0;
        if (i_load_type[LT_BYTE]) begin
            o_value = {{24{w_byte[7] & ~i_load_type[LT_UNSIGNED]}}, w_byte};
        end else if (i_load_type[LT_HWORD]) begin
            o_value      = {{16{w_hword[15] & ~i_load_type[LT_UNSIGNED]}}, w_hword};
            o_misaligned = i_offset[0];
        end else begin
            o_misaligned = |i_offset;
        end
    end

endmodule

// File: rtl/data_memory_read_interface.sv
// Tracks loads across the memory boundary: request reg, stall data hold, output reg.
module data_memory_read_interface
    import data_memory_read_interface_pkg::*;
(
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_stall,
    input  logic                          i_flush,
    data_memory_read_interface_if.slave   bus
);

    req_t  r_req;
    logic  r_held;
    word_t r_hold;
    out_t  r_out;

    word_t       w_data;
    word_t       w_value;
    logic        w_misaligned;
    logic [29:0] w_unused_addr;

    assign w_unused_addr = bus.long_addr[31:2];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_req.valid <= 1'b0;
        end else begin
            if (!i_stall && bus.req_valid) begin
                r_req.offset <= bus.long_addr[1:0];
                r_req.ltype  <= bus.load_type;
                r_req.dest   <= bus.dest_reg;
            end
            if (i_flush)
                r_req.valid <= 1'b0;
            else if (!i_stall)
                r_req.valid <= bus.req_valid;
        end
    end

    // RAM data is only guaranteed the cycle after the request; keep a copy across stalls.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush || !i_stall) begin
            r_held <= 1'b0;
        end else if (r_req.valid && !r_held) begin
            r_hold <= bus.mem_read_data;
            r_held <= 1'b1;
        end
    end

    assign w_data = r_held ? r_hold : bus.mem_read_data;

    data_memory_read_interface_load_extract u_extract (
        .i_offset     (r_req.offset),
        .i_load_type  (r_req.ltype),
        .i_word       (w_data),
        .o_value      (w_value),
        .o_misaligned (w_misaligned)
    );

    // Flush does not touch O: a load already returned still completes.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_out <= '0;
        else if (!i_stall)
            r_out <= {r_req.valid, r_req.dest, w_value, w_misaligned};
    end

    assign bus.out_valid    = r_out.valid;
    assign bus.out_dest_reg = r_out.dest;
    assign bus.load_value   = r_out.value;
    assign bus.misaligned   = r_out.misaligned;

endmodule
